// File: rtl/fxp_add_arbiter.sv
// Shared unsigned fixed-point adder fronted by a round-robin arbiter across NUM_REQ requesters.
// Latency: an operand pair accepted at edge t appears on rsp_* after edge t+1; one transaction every 3 cycles at best.
// Backpressure: rsp_ready=0 holds the result stable, and req_ready stays low until it is accepted.
//
// Optional build macro FXP_ARB_SAT_EN: clamp the result to DATA_W bits, so rsp_sum[DATA_W] is always 0.
//
// Ports:
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   req_valid/req_ready   per-requester handshake; at most one ready bit is set, and only in IDLE
//   req_a, req_b          packed operands, requester i at [i*DATA_W +: DATA_W]
//   rsp_valid/rsp_ready   result handshake
//   rsp_sum, rsp_id       DATA_W+1-bit sum and the index of the requester that owns it
module fxp_add_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 4,
    parameter int ID_W    = 2     // must equal $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] req_a,
    input  logic [NUM_REQ*DATA_W-1:0] req_b,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [DATA_W:0]           rsp_sum,
    output logic [ID_W-1:0]           rsp_id
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_e;

    // After reset the pointer sits on the last requester, so requester 0 is searched first.
    localparam logic [ID_W-1:0] LAST_GRANT_RST = ID_W'(NUM_REQ - 1);
    localparam logic [ID_W:0]   NUM_REQ_EXT    = (ID_W+1)'(NUM_REQ);

    state_e            state_q, state_d;
    logic [ID_W-1:0]   last_grant_q, last_grant_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [DATA_W:0]   rsp_sum_q, rsp_sum_d;
    logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
    logic              rsp_valid_q, rsp_valid_d;

    logic              any_vld;
    logic [ID_W-1:0]   winner;
    logic [ID_W:0]     cand;
    logic [NUM_REQ-1:0] grant_vec;
    logic [DATA_W:0]   sum_full;
    logic [DATA_W:0]   sum_res;

    // ------------------------------------------------------------------
    // Round-robin search: candidates last_grant+1, last_grant+2, ... with
    // wrap at NUM_REQ. cand is one bit wider than an index, so the sum of
    // pointer and offset never overflows before the wrap subtraction,
    // which also keeps non-power-of-two NUM_REQ correct.
    // ------------------------------------------------------------------
    always_comb begin
        any_vld = 1'b0;
        winner  = '0;
        cand    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = {1'b0, last_grant_q} + (ID_W+1)'(k);
            if (cand >= NUM_REQ_EXT) begin
                cand = cand - NUM_REQ_EXT;
            end
            if (!any_vld && req_valid[cand[ID_W-1:0]]) begin
                any_vld = 1'b1;
                winner  = cand[ID_W-1:0];
            end
        end
    end

    // ------------------------------------------------------------------
    // Shared adder, fed only from the captured operand registers.
    // ------------------------------------------------------------------
    always_comb begin
        sum_full = {1'b0, a_q} + {1'b0, b_q};
`ifdef FXP_ARB_SAT_EN
        sum_res = sum_full[DATA_W] ? {1'b0, {DATA_W{1'b1}}}
                                   : {1'b0, sum_full[DATA_W-1:0]};
`else
        sum_res = sum_full;
`endif
    end

    // ------------------------------------------------------------------
    // FSM next state and datapath enables.
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        id_d         = id_q;
        a_d          = a_q;
        b_d          = b_q;
        rsp_sum_d    = rsp_sum_q;
        rsp_id_d     = rsp_id_q;
        rsp_valid_d  = rsp_valid_q;
        grant_vec    = '0;

        unique case (state_q)
            IDLE: begin
                if (any_vld) begin
                    // The handshake completes on this edge: capture the
                    // winner's operands now, because they may change later.
                    grant_vec[winner] = 1'b1;
                    a_d               = req_a[winner*DATA_W +: DATA_W];
                    b_d               = req_b[winner*DATA_W +: DATA_W];
                    id_d              = winner;
                    last_grant_d      = winner;
                    state_d           = CALC;
                end
            end
            CALC: begin
                rsp_sum_d   = sum_res;
                rsp_id_d    = id_q;
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                rsp_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    // The state register already sits in IDLE during reset. Gating ready
    // with rst_n stops a waiting requester from seeing a handshake that
    // the flops would never act on.
    assign req_ready = rst_n ? grant_vec : '0;

    // ------------------------------------------------------------------
    // State and datapath registers.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= LAST_GRANT_RST;
            id_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            rsp_sum_q    <= '0;
            rsp_id_q     <= '0;
            rsp_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            id_q         <= id_d;
            a_q          <= a_d;
            b_q          <= b_d;
            rsp_sum_q    <= rsp_sum_d;
            rsp_id_q     <= rsp_id_d;
            rsp_valid_q  <= rsp_valid_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_sum   = rsp_sum_q;
    assign rsp_id    = rsp_id_q;

endmodule

// File: tb/tb_fxp_add_arbiter.sv
// Self-checking bench for fxp_add_arbiter (NUM_REQ=4, DATA_W=4).
// Table vectors cover the hand-picked cases; a round-robin and sum model drives the random phase.
// Checks are taken on the falling edge, and inputs are driven 1 time unit after the rising edge.
module tb_fxp_add_arbiter;

    localparam int N = 4;
    localparam int W = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N-1:0]  req_valid;
    logic [N-1:0]  req_ready;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [W:0]    rsp_sum;
    logic [1:0]    rsp_id;

    int tests = 0;
    int fails = 0;
    int model_last;

    always #5 clk = ~clk;

    fxp_add_arbiter #(.NUM_REQ(N), .DATA_W(W), .ID_W(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_sum   (rsp_sum),
        .rsp_id    (rsp_id)
    );

    typedef struct {
        logic [3:0]  v;
        logic [15:0] a;
        logic [15:0] b;
        int          hold;
        int          early;
        int          exp_id;
        int          exp_sum;
        int          exp_sat;
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Round robin: the first requester holding valid, searching upward from last+1.
    function automatic int model_winner(input logic [3:0] v, input int last);
        for (int k = 1; k <= N; k++) begin
            if (((v >> ((last + k) % N)) & 4'd1) != 4'd0) return (last + k) % N;
        end
        return -1;
    endfunction

    function automatic int model_sum(input int a, input int b);
        int s;
        s = a + b;
`ifdef FXP_ARB_SAT_EN
        if (s > 15) s = 15;
`endif
        return s;
    endfunction

    function automatic int nib(input logic [15:0] x, input int i);
        return int'((x >> (4 * i)) & 16'hF);
    endfunction

    // Runs one full transaction. Call at posedge+1 with the DUT in IDLE.
    task automatic txn(input string nm, input logic [3:0] v, input logic [15:0] a,
                       input logic [15:0] b, input int hold, input int early,
                       input int exp_id, input int exp_sum);
        int n;
        req_valid = v;
        req_a     = a;
        req_b     = b;
        rsp_ready = (early != 0);
        #1;
        n = 0;
        while (req_ready == '0 && n < 6) begin
            @(posedge clk); #1;
            n++;
        end
        chk({nm, "_grant"}, 32'(req_ready), 32'(1 << exp_id));
        @(posedge clk); #1;
        // Operands and valids are scrambled after acceptance and must not matter.
        req_valid = 4'($urandom);
        req_a     = 16'($urandom);
        req_b     = 16'($urandom);
        @(negedge clk);
        chk({nm, "_calc_ready"}, 32'(req_ready), 0);
        chk({nm, "_calc_valid"}, 32'(rsp_valid), 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk({nm, "_valid"}, 32'(rsp_valid), 1);
        chk({nm, "_sum"}, 32'(rsp_sum), exp_sum);
        chk({nm, "_id"}, 32'(rsp_id), exp_id);
        chk({nm, "_resp_ready"}, 32'(req_ready), 0);
        rsp_ready = 1'b0;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk({nm, "_hold_valid"}, 32'(rsp_valid), 1);
            chk({nm, "_hold_sum"}, 32'(rsp_sum), exp_sum);
            chk({nm, "_hold_id"}, 32'(rsp_id), exp_id);
            chk({nm, "_hold_ready"}, 32'(req_ready), 0);
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk({nm, "_done_valid"}, 32'(rsp_valid), 0);
        rsp_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] sa, sb;
        int          exp_q[$];
        int          ngrant, last_acc, e, id;
        logic [3:0]  rv;
        logic [15:0] ra, rb;

        // v, a, b, hold, early, id, sum, saturated sum
        tbl[0] = '{4'b0001, 16'h000B, 16'h0006, 0, 1, 0, 17, 15};
        tbl[1] = '{4'b1111, 16'hFFFF, 16'hFFFF, 5, 0, 1, 30, 15};
        tbl[2] = '{4'b0100, 16'h0000, 16'h0000, 1, 1, 2,  0,  0};
        tbl[3] = '{4'b1000, 16'h5000, 16'h3000, 0, 0, 3,  8,  8};
        tbl[4] = '{4'b1001, 16'h0007, 16'h0009, 2, 0, 0, 16, 15};
        tbl[5] = '{4'b1000, 16'hA000, 16'hA000, 0, 1, 3, 20, 15};

        // Reset state, with requests already pending.
        rst_n     = 1'b0;
        req_valid = 4'hF;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        #3;
        chk("rst_valid", 32'(rsp_valid), 0);
        chk("rst_sum", 32'(rsp_sum), 0);
        chk("rst_id", 32'(rsp_id), 0);
        chk("rst_ready", 32'(req_ready), 0);
        req_valid = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_last = N - 1;

        // Table vectors.
        for (int i = 0; i < 6; i++) begin
`ifdef FXP_ARB_SAT_EN
            txn($sformatf("vec%0d", i), tbl[i].v, tbl[i].a, tbl[i].b, tbl[i].hold,
                tbl[i].early, tbl[i].exp_id, tbl[i].exp_sat);
`else
            txn($sformatf("vec%0d", i), tbl[i].v, tbl[i].a, tbl[i].b, tbl[i].hold,
                tbl[i].early, tbl[i].exp_id, tbl[i].exp_sum);
`endif
            model_last = tbl[i].exp_id;
        end

        // Reset asserted while a result is waiting in RESP.
        req_valid = 4'b0010;
        req_a     = 16'h0030;
        req_b     = 16'h0020;
        #1;
        chk("midrst_grant", 32'(req_ready), 32'b0010);
        @(posedge clk); #1;
        req_valid = 4'hF;
        @(posedge clk); #1;
        @(negedge clk);
        chk("midrst_pre_valid", 32'(rsp_valid), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", 32'(rsp_valid), 0);
        chk("midrst_sum", 32'(rsp_sum), 0);
        chk("midrst_ready", 32'(req_ready), 0);

        // After release, all requesters are valid and rsp_ready is held high.
        sa = 16'($urandom);
        sb = 16'($urandom);
        req_a     = sa;
        req_b     = sb;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rst_n      = 1'b1;
        model_last = N - 1;
        ngrant     = 0;
        last_acc   = -100;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (req_ready != '0) begin
                e = model_winner(4'hF, model_last);
                chk("stream_grant", 32'(req_ready), 32'(1 << e));
                if (ngrant > 0) chk("stream_interval", c - last_acc, 3);
                last_acc   = c;
                model_last = e;
                ngrant++;
                exp_q.push_back(e);
            end
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    chk("stream_unexpected_rsp", 32'(rsp_valid), 0);
                end else begin
                    id = exp_q.pop_front();
                    chk("stream_id", 32'(rsp_id), id);
                    chk("stream_sum", 32'(rsp_sum), model_sum(nib(sa, id), nib(sb, id)));
                end
            end
            @(posedge clk); #1;
        end
        chk("stream_grant_count", ngrant, 7);
        req_valid = '0;
        repeat (4) begin
            @(posedge clk); #1;
        end
        rsp_ready = 1'b0;
        chk("drain_valid", 32'(rsp_valid), 0);

        // Random traffic checked against the model.
        for (int r = 0; r < 40; r++) begin
            rv = 4'($urandom_range(0, 15));
            if (rv == 4'd0) begin
                req_valid = '0;
                rsp_ready = 1'($urandom);
                @(negedge clk);
                chk("rand_idle_ready", 32'(req_ready), 0);
                chk("rand_idle_valid", 32'(rsp_valid), 0);
                @(posedge clk); #1;
            end else begin
                ra = 16'($urandom);
                rb = 16'($urandom);
                e  = model_winner(rv, model_last);
                txn($sformatf("rand%0d", r), rv, ra, rb, $urandom_range(0, 3),
                    $urandom_range(0, 1), e, model_sum(nib(ra, e), nib(rb, e)));
                model_last = e;
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
